// File: rtl/dm_pipe.sv
// dm_pipe: byte-addressed little-endian data memory with one registered, handshaked response.
// Define DM_MISALIGN_TRAP_EN to reject misaligned H/HU/W accesses; otherwise low address bits are ignored.
module dm_pipe #(
  parameter int ADDR_W = 9,
  parameter int DEPTH  = 128
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_op,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(DEPTH);

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_B  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  typedef enum logic [1:0] {
    SZ_W,
    SZ_H,
    SZ_B
  } size_e;

  logic [31:0]       mem [DEPTH];

  logic              accept;
  logic [ADDR_W-3:0] word_idx;
  logic [IDX_W-1:0]  mem_idx;
  logic              in_range;
  logic              misaligned;
  logic              err;
  size_e             size;
  logic              sign_ext;
  logic [3:0]        lane_en;
  logic [31:0]       lane_wdata;
  logic [31:0]       rd_word;
  logic [7:0]        sel_byte;
  logic [15:0]       sel_half;
  logic [31:0]       load_data;

  // The response slot frees up in the same cycle its contents are consumed.
  assign req_ready = !rsp_valid || rsp_ready;
  assign accept    = req_valid && req_ready;

  assign word_idx = req_addr[ADDR_W-1:2];
  assign mem_idx  = word_idx[IDX_W-1:0];
  assign in_range = {1'b0, word_idx} < DEPTH_L;

  // NOTE: every signal assigned in always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    size     = SZ_W;
    sign_ext = 1'b0;
    case (req_op)
      OP_H:    begin size = SZ_H; sign_ext = 1'b1; end
      OP_HU:   size = SZ_H;
      OP_B:    begin size = SZ_B; sign_ext = 1'b1; end
      OP_BU:   size = SZ_B;
      OP_W:    size = SZ_W;
      default: size = SZ_W;
    endcase
  end

`ifdef DM_MISALIGN_TRAP_EN
  assign misaligned = ((size == SZ_H) && req_addr[0]) ||
                      ((size == SZ_W) && (req_addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  assign err = !in_range || misaligned;

  // Lane enables and replicated store data; the same lane rule drives load extraction.
  always_comb begin
    lane_en    = 4'b1111;
    lane_wdata = req_wdata;
    case (size)
      SZ_B: begin
        lane_en    = 4'b0001 << req_addr[1:0];
        lane_wdata = {4{req_wdata[7:0]}};
      end
      SZ_H: begin
        lane_en    = req_addr[1] ? 4'b1100 : 4'b0011;
        lane_wdata = {2{req_wdata[15:0]}};
      end
      default: begin
        lane_en    = 4'b1111;
        lane_wdata = req_wdata;
      end
    endcase
  end

  // NOTE: the word array has no reset; its contents are undefined until written, so it stays plain RAM.
  always_ff @(posedge clk) begin
    if (accept && req_we && !err) begin
      for (int i = 0; i < 4; i++) begin
        if (lane_en[i]) mem[mem_idx][8*i +: 8] <= lane_wdata[8*i +: 8];
      end
    end
  end

  assign rd_word = mem[mem_idx];

  always_comb begin
    sel_byte = rd_word[7:0];
    case (req_addr[1:0])
      2'd0: sel_byte = rd_word[7:0];
      2'd1: sel_byte = rd_word[15:8];
      2'd2: sel_byte = rd_word[23:16];
      2'd3: sel_byte = rd_word[31:24];
      default: sel_byte = rd_word[7:0];
    endcase
  end

  assign sel_half = req_addr[1] ? rd_word[31:16] : rd_word[15:0];

  always_comb begin
    load_data = rd_word;
    case (size)
      SZ_B:    load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
      SZ_H:    load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
      default: load_data = rd_word;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (accept) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      rsp_rdata <= (req_we || err) ? 32'h0 : load_data;
    end else if (rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dm_pipe.sv
// Directed self-checking bench for dm_pipe (ADDR_W=10, DEPTH=128); expectations follow DM_MISALIGN_TRAP_EN.
module tb_dm_pipe;

  localparam int ADDR_W = 10;
  localparam int DEPTH  = 128;

  localparam logic [2:0] OP_W  = 3'b000;
  localparam logic [2:0] OP_H  = 3'b001;
  localparam logic [2:0] OP_HU = 3'b010;
  localparam logic [2:0] OP_B  = 3'b011;
  localparam logic [2:0] OP_BU = 3'b100;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_we = 1'b0;
  logic [2:0]        req_op = 3'b000;
  logic [ADDR_W-1:0] req_addr = '0;
  logic [31:0]       req_wdata = 32'h0;
  logic              rsp_valid;
  logic              rsp_ready = 1'b1;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;

  int n_cmp = 0;
  int n_bad = 0;

  dm_pipe #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rstn      (rstn),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_op    (req_op),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One request with rsp_ready held high; returns the registered response.
  task automatic xfer(input string tag, input logic we, input logic [2:0] op,
                      input logic [ADDR_W-1:0] addr, input logic [31:0] wdata,
                      output logic [31:0] rdata, output logic err);
    int n;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_we    = we;
    req_op    = op;
    req_addr  = addr;
    req_wdata = wdata;
    n = 0;
    while (!req_ready && n < 10) begin
      tick();
      n++;
    end
    if (n == 10) check({tag, "_ready_timeout"}, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    check({tag, "_valid"}, 32'(rsp_valid), 32'd1);
    rdata = rsp_rdata;
    err   = rsp_err;
  endtask

  task automatic store(input string tag, input logic [2:0] op,
                       input logic [ADDR_W-1:0] addr, input logic [31:0] wdata);
    logic [31:0] rd;
    logic        e;
    xfer(tag, 1'b1, op, addr, wdata, rd, e);
  endtask

  task automatic load_check(input string tag, input logic [2:0] op,
                            input logic [ADDR_W-1:0] addr,
                            input logic [31:0] exp_data, input logic exp_err);
    logic [31:0] rd;
    logic        e;
    xfer(tag, 1'b0, op, addr, 32'h0, rd, e);
    check({tag, "_data"}, rd, exp_data);
    check({tag, "_err"}, 32'(e), 32'(exp_err));
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;

    // Reset values
    #12;
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'h0);
    check("rst_err", 32'(rsp_err), 32'd0);
    check("rst_ready", 32'(req_ready), 32'd1);
    rstn = 1'b1;
    tick();

    // Store pending under backpressure, then asynchronous reset drops its response
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b1; req_op = OP_W; req_addr = 10'h040; req_wdata = 32'hCAFEF00D;
    tick();
    req_valid = 1'b0;
    check("pend_valid", 32'(rsp_valid), 32'd1);
    #2 rstn = 1'b0;
    #1 check("async_rst_valid", 32'(rsp_valid), 32'd0);
    #1 rstn = 1'b1;
    check("post_rst_ready", 32'(req_ready), 32'd1);
    rsp_ready = 1'b1;
    tick();
    load_check("kept_store", OP_W, 10'h040, 32'hCAFEF00D, 1'b0);

    // Byte stores use only the low byte of wdata
    store("sb0", OP_B, 10'h010, 32'hAAAAAA11);
    store("sb1", OP_B, 10'h011, 32'hBBBBBB22);
    store("sb2", OP_B, 10'h012, 32'hCCCCCC33);
    xfer("sb3", 1'b1, OP_B, 10'h013, 32'h55555584, rd, e);
    check("store_rdata_zero", rd, 32'h0);
    check("store_err_zero", 32'(e), 32'd0);
    load_check("lw_10", OP_W, 10'h010, 32'h84332211, 1'b0);
    load_check("lb_13", OP_B, 10'h013, 32'hFFFFFF84, 1'b0);
    load_check("lbu_13", OP_BU, 10'h013, 32'h00000084, 1'b0);
    load_check("lb_11", OP_B, 10'h011, 32'h00000022, 1'b0);
    load_check("lh_12", OP_H, 10'h012, 32'hFFFF8433, 1'b0);

    // Halfword store into the upper lanes
    store("sw_20", OP_W, 10'h020, 32'h00000000);
    store("sh_22", OP_H, 10'h022, 32'h12348001);
    load_check("lw_20", OP_W, 10'h020, 32'h80010000, 1'b0);
    load_check("lh_22", OP_H, 10'h022, 32'hFFFF8001, 1'b0);
    load_check("lhu_22", OP_HU, 10'h022, 32'h00008001, 1'b0);
    load_check("lhu_20", OP_HU, 10'h020, 32'h00000000, 1'b0);

    // Back-to-back store then load of the same word
    rsp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_op = OP_W; req_addr = 10'h004; req_wdata = 32'hDEADBEEF;
    tick();
    check("b2b_st_valid", 32'(rsp_valid), 32'd1);
    check("b2b_st_rdata", rsp_rdata, 32'h0);
    check("b2b_ready", 32'(req_ready), 32'd1);
    req_we = 1'b0;
    tick();
    check("b2b_ld_valid", 32'(rsp_valid), 32'd1);
    check("b2b_ld_rdata", rsp_rdata, 32'hDEADBEEF);
    req_valid = 1'b0;
    tick();
    check("b2b_drain", 32'(rsp_valid), 32'd0);

    // Backpressure: a presented store must be ignored while the response is held
    rsp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_op = OP_W; req_addr = 10'h004;
    tick();
    req_we = 1'b1; req_wdata = 32'h11111111;
    for (int i = 0; i < 3; i++) begin
      check("bp_ready", 32'(req_ready), 32'd0);
      check("bp_valid", 32'(rsp_valid), 32'd1);
      check("bp_rdata", rsp_rdata, 32'hDEADBEEF);
      tick();
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    check("bp_drain", 32'(rsp_valid), 32'd0);
    load_check("bp_not_written", OP_W, 10'h004, 32'hDEADBEEF, 1'b0);

    // Out of range: word 128 must not alias onto word 0
    store("sw_0", OP_W, 10'h000, 32'h0BADF00D);
    store("sw_1fc", OP_W, 10'h1FC, 32'h7E57CA5E);
    xfer("sw_oor", 1'b1, OP_W, 10'h200, 32'h12345678, rd, e);
    check("sw_oor_err", 32'(e), 32'd1);
    check("sw_oor_rdata", rd, 32'h0);
    load_check("oor_no_alias", OP_W, 10'h000, 32'h0BADF00D, 1'b0);
    load_check("lw_oor", OP_W, 10'h200, 32'h0, 1'b1);
    load_check("lw_last", OP_W, 10'h1FC, 32'h7E57CA5E, 1'b0);

    // Undefined op codes act as word accesses
    store("sw_op7", 3'b111, 10'h030, 32'h01020304);
    load_check("lw_op5", 3'b101, 10'h030, 32'h01020304, 1'b0);

    // Misalignment
`ifdef DM_MISALIGN_TRAP_EN
    load_check("lw_21", OP_W, 10'h021, 32'h0, 1'b1);
    xfer("sh_23", 1'b1, OP_H, 10'h023, 32'h00005AA5, rd, e);
    check("sh_23_err", 32'(e), 32'd1);
    load_check("after_sh_23", OP_W, 10'h020, 32'h80010000, 1'b0);
`else
    load_check("lw_21", OP_W, 10'h021, 32'h80010000, 1'b0);
    xfer("sh_23", 1'b1, OP_H, 10'h023, 32'h00005AA5, rd, e);
    check("sh_23_err", 32'(e), 32'd0);
    load_check("after_sh_23", OP_W, 10'h020, 32'h5AA50000, 1'b0);
`endif
    load_check("lbu_21_aligned", OP_BU, 10'h021, 32'h00000000, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
